// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception commit unit: stall bus macros, CP0
// exception codes, exception-flag bit positions and default parameters.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

package except_ctrl_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_TR   = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    // mem_exc_flags = {eret,ades,adel,brk,syscall,trap,ov,ri,adel_if}
    localparam int FLAG_ADEL_IF = 0;
    localparam int FLAG_RI      = 1;
    localparam int FLAG_OV      = 2;
    localparam int FLAG_TRAP    = 3;
    localparam int FLAG_SYSCALL = 4;
    localparam int FLAG_BRK     = 5;
    localparam int FLAG_ADEL    = 6;
    localparam int FLAG_ADES    = 7;
    localparam int FLAG_ERET    = 8;

    localparam int STALL_MEM = 4;

    localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;
    localparam int          DRAIN_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        BV_NONE = 2'd0,
        BV_PC   = 2'd1,
        BV_DATA = 2'd2
    } bv_sel_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder: picks the single winning code and
// tells the caller which source feeds BadVAddr.
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic [8:0]  flags,
    input  logic        int_pending,
    output logic [31:0] code,
    output bv_sel_e     bv_sel
);

    // Fixed-priority select; ERET sits last so any real fault overrides it
    always_comb begin
        code   = EXC_NONE;
        bv_sel = BV_NONE;
        if (int_pending) begin
            code = EXC_INT;
        end else if (flags[FLAG_ADEL_IF]) begin
            code   = EXC_ADEL;
            bv_sel = BV_PC;
        end else if (flags[FLAG_RI]) begin
            code = EXC_RI;
        end else if (flags[FLAG_OV]) begin
            code = EXC_OV;
        end else if (flags[FLAG_TRAP]) begin
            code = EXC_TR;
        end else if (flags[FLAG_SYSCALL]) begin
            code = EXC_SYS;
        end else if (flags[FLAG_BRK]) begin
            code = EXC_BP;
        end else if (flags[FLAG_ADEL]) begin
            code   = EXC_ADEL;
            bv_sel = BV_DATA;
        end else if (flags[FLAG_ADES]) begin
            code   = EXC_ADES;
            bv_sel = BV_DATA;
        end else if (flags[FLAG_ERET]) begin
            code = EXC_ERET;
        end else begin
            code   = EXC_NONE;
            bv_sel = BV_NONE;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Exception commit unit: drives the CP0 update bus and pipeline redirect for the
// commit-stage instruction, then blocks new exceptions for a short drain window.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [`StallBus] stall,
    input  logic             mem_valid,
    input  logic [31:0]      mem_pc,
    input  logic             mem_in_delayslot,
    input  logic [8:0]       mem_exc_flags,
    input  logic [31:0]      mem_bad_vaddr,
    input  logic [31:0]      status_i,
    input  logic [31:0]      cause_i,
    input  logic [31:0]      epc_i,
    output logic [31:0]      excepttype_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      bad_vaddr_o,
    output logic             is_in_delayslot_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_e      state_r;
    logic [2:0]  cnt_r;
    logic        int_pending_r;
    logic        int_req_s;
    logic        take_s;
    logic [31:0] code_s;
    bv_sel_e     bv_sel_s;
    logic        unused_bits_s;

    assign int_req_s = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    // Reset also gates the bus so CP0 never sees a commit while rst is held
    assign take_s    = mem_valid & ~stall[STALL_MEM] & (state_r == ST_IDLE) & ~rst;
    assign unused_bits_s = ^{status_i[31:16], status_i[7:2], cause_i[31:16],
                             cause_i[7:0], stall[5], stall[3:0]};

    exc_prio_enc u_prio (
        .flags       (mem_exc_flags),
        .int_pending (int_pending_r),
        .code        (code_s),
        .bv_sel      (bv_sel_s)
    );

    // CP0 update bus and redirect, valid only in the commit cycle
    always_comb begin
        excepttype_o      = EXC_NONE;
        pc_o              = 32'h0000_0000;
        bad_vaddr_o       = 32'h0000_0000;
        is_in_delayslot_o = 1'b0;
        flush_o           = 1'b0;
        new_pc_o          = 32'h0000_0000;
        if (take_s && (code_s != EXC_NONE)) begin
            excepttype_o      = code_s;
            pc_o              = mem_pc;
            is_in_delayslot_o = mem_in_delayslot;
            flush_o           = 1'b1;
            case (bv_sel_s)
                BV_PC:   bad_vaddr_o = mem_pc;
                BV_DATA: bad_vaddr_o = mem_bad_vaddr;
                default: bad_vaddr_o = 32'h0000_0000;
            endcase
            if (code_s == EXC_ERET) begin
                new_pc_o = epc_i;
            end else begin
                new_pc_o = EXC_VECTOR;
            end
        end else begin
            flush_o = 1'b0;
        end
    end

    // Interrupt latch and drain-window state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 3'd0;
            int_pending_r <= 1'b0;
        end else begin
            if (flush_o) begin
                int_pending_r <= 1'b0;
            end else if (stall[STALL_MEM]) begin
                int_pending_r <= int_pending_r;
            end else begin
                int_pending_r <= int_req_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (flush_o) begin
                        state_r <= ST_DRAIN;
                        cnt_r   <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == 3'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception commit unit at the MEM/commit boundary, directly upstream of the CP0 register file.
- Each cycle it takes the commit-stage instruction's exception flags, pending interrupt state and CP0 status/cause/epc.
- It selects at most one exception (or ERET) per cycle and drives the CP0 update bus (excepttype, pc, bad_vaddr, delay-slot flag).
- It raises the pipeline flush and redirect PC, then suppresses further commits for a short drain window while CP0 state settles.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- DRAIN_CYCLES, 2, cycles after a flush during which new exceptions/interrupts are not taken (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  `StallBus  pipeline stall vector; stall[4] high = commit stage held
- mem_valid  in  1  commit-stage slot holds a real instruction
- mem_pc  in  32  PC of the commit-stage instruction
- mem_in_delayslot  in  1  instruction is in a branch delay slot
- mem_exc_flags  in  9  {eret,ades,adel,brk,syscall,trap,ov,ri,adel_if}
- mem_bad_vaddr  in  32  faulting data address for load/store
- status_i  in  32  CP0 Status (already bypassed)
- cause_i  in  32  CP0 Cause (already bypassed)
- epc_i  in  32  CP0 EPC (already bypassed)
- excepttype_o  out  32  exception code to CP0; 0 = none
- pc_o  out  32  faulting PC to CP0
- bad_vaddr_o  out  32  BadVAddr value to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- flush_o  out  1  flush all stages younger than commit
- new_pc_o  out  32  redirect target, valid while flush_o is high

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, drain counter 0, int_pending 0.
- Commit condition: take = mem_valid & ~stall[4] & state==IDLE.
- Interrupt request:
  - int_req = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
  - int_req is registered into int_pending every cycle.
  - int_pending is cleared when an interrupt is taken or on any flush.
  - The interrupt is attached to the next instruction with take high.
- Priority, highest first, with excepttype codes:
  - int_pending → 32'h1
  - adel_if → 32'h4
  - ri → 32'hA
  - ov → 32'hC
  - trap → 32'hD
  - syscall → 32'h8
  - brk → 32'h9
  - adel → 32'h4
  - ades → 32'h5
  - eret → 32'hE
- CP0 bus outputs are combinational in the take cycle and sampled by CP0 at the following edge.
  - pc_o = mem_pc.
  - is_in_delayslot_o = mem_in_delayslot.
  - bad_vaddr_o = mem_pc for adel_if; mem_bad_vaddr for adel/ades; 0 otherwise.
  - When take is low or no flag/interrupt is selected, all CP0 bus outputs are 0.
- Redirect:
  - flush_o = 1 in the same take cycle whenever excepttype_o != 0.
  - new_pc_o = epc_i for ERET; EXC_VECTOR for all other codes.
- State machine:
  - IDLE → DRAIN on flush; the counter loads DRAIN_CYCLES-1.
  - DRAIN: counter decrements each cycle; take is forced low; flush_o stays 0; int_pending is still sampled.
  - DRAIN → IDLE when the counter reaches 0.
- Stall: with stall[4]=1 nothing commits and int_pending holds its value. The instruction is evaluated again when stall releases.
- Simultaneous events:
  - Interrupt plus a synchronous flag on the same instruction → interrupt wins (code 1).
  - ERET plus any other flag → the other flag wins.
- Reset asserted in DRAIN → state returns to IDLE and all outputs go to 0 on the next edge.
- mem_valid=0 with flags set → flags are ignored, and a pending interrupt is not taken.

Decomposition:
- Shared package/defines:
  - EXC_* code constants (INT=1, ADEL=4, ADES=5, SYS=8, BP=9, RI=A, OV=C, TR=D, ERET=E).
  - Bit indices of mem_exc_flags.
  - EXC_VECTOR default.
  - Existing `StallBus / `Stop / `NoStop.
- One natural sub-module: exc_prio_enc.
  - Purely combinational: flags + int_pending → code and bad_vaddr select.
  - The FSM, counter and interrupt latch stay in except_ctrl.

Test Plan:
- Syscall: mem_valid=1, syscall flag, mem_pc=0xBFC00100, not in delay slot → excepttype_o=0x8, pc_o=0xBFC00100, flush_o=1, new_pc_o=0xBFC00380. The next 2 cycles ignore a second syscall.
- Load fault: adel, mem_bad_vaddr=0x80000003 → excepttype_o=0x4, bad_vaddr_o=0x80000003. A flush_o pulse follows; repeat with adel_if and mem_pc=0x80000001 → bad_vaddr_o=0x80000001.
- Interrupt: status=0x0000FF01, cause[10]=1, mem_valid=0 for 3 cycles → no flush. Then mem_valid=1, pc=0xBFC00200, delay slot=1 → excepttype_o=0x1, is_in_delayslot_o=1, flush_o=1.
- ERET: epc_i=0xBFC00500, eret flag → excepttype_o=0xE, new_pc_o=0xBFC00500. With ov also set → excepttype_o=0xC, new_pc_o=0xBFC00380.
- Stall: ri flag with stall[4]=1 for 4 cycles → flush_o=0 throughout. When stall drops → excepttype_o=0xA for exactly one cycle.
- Reset: assert rst in the first DRAIN cycle → all outputs 0 next cycle. An exception in the first cycle after rst deasserts is taken immediately.
